// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and the
// writeback consumer. "master" is the bench/system side driving pushes and
// taking pops; "slave" is the FIFO itself.
interface alu_result_fifo_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned OP_LEN = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_sum;
    logic [OP_LEN-1:0] in_opcode;
    logic              in_cout;
    logic              in_neg;
    logic              in_ovf;
    logic              in_zero;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic [OP_LEN-1:0] out_opcode;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_sum, in_opcode, in_cout, in_neg, in_ovf, in_zero,
        input  in_ready,
        input  out_valid, out_sum, out_opcode, out_flags,
        output out_ready
    );

    modport slave (
        input  in_valid, in_sum, in_opcode, in_cout, in_neg, in_ovf, in_zero,
        output in_ready,
        output out_valid, out_sum, out_opcode, out_flags,
        input  out_ready
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures ALU results (sum, opcode tag, flags) into a
// DEPTH-entry FIFO and hands them to writeback over valid/ready.
// Reports occupancy and a saturating backpressure-stall counter.
// Optional feature macro: ALU_STICKY_FLAGS_EN (sticky overflow/carry flags).
module alu_result_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned OP_LEN = 5,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_result_fifo_if.slave         bus,
    input  logic                     sticky_clr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic                     sticky_ovf,
    output logic                     sticky_cout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [WIDTH-1:0]  sum_mem_q   [DEPTH];
    logic [WIDTH-1:0]  sum_mem_d   [DEPTH];
    logic [OP_LEN-1:0] op_mem_q    [DEPTH];
    logic [OP_LEN-1:0] op_mem_d    [DEPTH];
    logic [3:0]        flags_mem_q [DEPTH];
    logic [3:0]        flags_mem_d [DEPTH];

    logic push;
    logic pop;

    // Handshakes use only registered ready/valid, so no comb path from out_ready to in_ready.
    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // Pointer, occupancy, status and storage next-state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        sum_mem_d   = sum_mem_q;
        op_mem_d    = op_mem_q;
        flags_mem_d = flags_mem_q;

        if (push) begin
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            sum_mem_d[wr_ptr_q]   = bus.in_sum;
            op_mem_d[wr_ptr_q]    = bus.in_opcode;
            flags_mem_d[wr_ptr_q] = {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d != OCC_W'(DEPTH));
        out_valid_d = (count_d != OCC_W'(0));

        if (bus.in_valid && !in_ready_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; storage is cleared so outputs read 0 before the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                sum_mem_q[i]   <= '0;
                op_mem_q[i]    <= '0;
                flags_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            sum_mem_q   <= sum_mem_d;
            op_mem_q    <= op_mem_d;
            flags_mem_q <= flags_mem_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = sum_mem_q[rd_ptr_q];
    assign bus.out_opcode = op_mem_q[rd_ptr_q];
    assign bus.out_flags  = flags_mem_q[rd_ptr_q];
    assign count          = count_q;
    assign stall_cnt      = stall_cnt_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic sticky_ovf_q,  sticky_ovf_d;
    logic sticky_cout_q, sticky_cout_d;

    // Sticky flags: a setting push overrides a same-cycle clear.
    always_comb begin
        sticky_ovf_d  = sticky_ovf_q;
        sticky_cout_d = sticky_cout_q;
        if (sticky_clr) begin
            sticky_ovf_d  = 1'b0;
            sticky_cout_d = 1'b0;
        end
        if (push && bus.in_ovf) begin
            sticky_ovf_d = 1'b1;
        end
        if (push && bus.in_cout) begin
            sticky_cout_d = 1'b1;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf_q  <= 1'b0;
            sticky_cout_q <= 1'b0;
        end else begin
            sticky_ovf_q  <= sticky_ovf_d;
            sticky_cout_q <= sticky_cout_d;
        end
    end

    assign sticky_ovf  = sticky_ovf_q;
    assign sticky_cout = sticky_cout_q;
`else
    // Feature absent: clear input is a don't-care, flags tie low.
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovf        = 1'b0;
    assign sticky_cout       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, single push/pop, fill/stall,
// drain order, concurrent push/pop with wrap, sticky flags, counter
// saturation (second instance with CNT_W=4) and asynchronous reset.
module tb_alu_result_fifo;

`ifdef ALU_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst;
    logic a_clr;
    logic b_clr;
    logic [2:0]  a_count;
    logic [15:0] a_stall;
    logic        a_sovf, a_scout;
    logic [2:0]  b_count;
    logic [3:0]  b_stall;
    logic        b_sovf, b_scout;

    int checks = 0;
    int errors = 0;

    // Model entry: {sum, opcode, flags{cout,neg,ovf,zero}}
    logic [40:0] q[$];
    logic [40:0] fill_vec [4];
    logic [40:0] ent;

    alu_result_fifo_if #(.WIDTH(32), .OP_LEN(5)) a_if ();
    alu_result_fifo_if #(.WIDTH(32), .OP_LEN(5)) b_if ();

    alu_result_fifo #(.WIDTH(32), .OP_LEN(5), .DEPTH(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave), .sticky_clr(a_clr),
        .count(a_count), .stall_cnt(a_stall), .sticky_ovf(a_sovf), .sticky_cout(a_scout)
    );

    alu_result_fifo #(.WIDTH(32), .OP_LEN(5), .DEPTH(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave), .sticky_clr(b_clr),
        .count(b_count), .stall_cnt(b_stall), .sticky_ovf(b_sovf), .sticky_cout(b_scout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [40:0] e);
        a_if.in_valid  = v;
        a_if.in_sum    = e[40:9];
        a_if.in_opcode = e[8:4];
        a_if.in_cout   = e[3];
        a_if.in_neg    = e[2];
        a_if.in_ovf    = e[1];
        a_if.in_zero   = e[0];
    endtask

    function automatic logic [40:0] a_head();
        return {a_if.out_sum, a_if.out_opcode, a_if.out_flags};
    endfunction

    initial begin
        rst = 1'b1;
        a_clr = 1'b0;
        b_clr = 1'b0;
        drive_a(1'b0, 41'd0);
        a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_sum = 32'h0; b_if.in_opcode = 5'd0;
        b_if.in_cout = 1'b0; b_if.in_neg = 1'b0; b_if.in_ovf = 1'b0; b_if.in_zero = 1'b0;
        b_if.out_ready = 1'b0;
        fill_vec[0] = {32'h0000_0009, 5'd1, 4'b0000};
        fill_vec[1] = {32'hFFFF_FFF7, 5'd2, 4'b1100};
        fill_vec[2] = {32'h0000_0005, 5'd3, 4'b0001};
        fill_vec[3] = {32'hFFFF_FFF7, 5'd4, 4'b0110};

        repeat (2) @(negedge clk);
        check("rst_count",    64'(a_count), 64'd0);
        check("rst_in_ready", 64'(a_if.in_ready), 64'd1);
        check("rst_out_valid",64'(a_if.out_valid), 64'd0);
        check("rst_stall",    64'(a_stall), 64'd0);
        check("rst_head",     64'(a_head()), 64'd0);
        check("rst_sticky",   64'({a_sovf, a_scout}), 64'd0);
        rst = 1'b0;

        // Saturation on CNT_W=4 instance: 4 pushes then continuous stall.
        b_if.in_valid = 1'b1;
        b_if.in_sum   = 32'h55;
        repeat (18) @(negedge clk);
        check("sat_b_count",  64'(b_count), 64'd4);
        check("sat_b_14",     64'(b_stall), 64'd14);
        repeat (6) @(negedge clk);
        check("sat_b_15",     64'(b_stall), 64'd15);
        b_if.in_valid = 1'b0;

        // Single push then pop.
        drive_a(1'b1, fill_vec[0]);
        @(negedge clk);
        drive_a(1'b0, fill_vec[0]);
        check("single_valid", 64'(a_if.out_valid), 64'd1);
        check("single_head",  64'(a_head()), 64'(fill_vec[0]));
        check("single_count", 64'(a_count), 64'd1);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b0;
        check("single_empty", 64'(a_if.out_valid), 64'd0);
        check("single_cnt0",  64'(a_count), 64'd0);

        // Fill 4 entries, then hold in_valid 3 more cycles against full.
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, fill_vec[i]);
            @(negedge clk);
        end
        check("fill_ready0",  64'(a_if.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        drive_a(1'b0, fill_vec[3]);
        check("fill_count",   64'(a_count), 64'd4);
        check("fill_ready",   64'(a_if.in_ready), 64'd0);
        check("fill_stall",   64'(a_stall), 64'd3);
        check("fill_sticky",  64'({a_sovf, a_scout}), STICKY ? 64'd3 : 64'd0);

        // Drain in order.
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), 64'(a_head()), 64'(fill_vec[i]));
            @(negedge clk);
        end
        a_if.out_ready = 1'b0;
        check("drain_empty",  64'(a_if.out_valid), 64'd0);
        check("drain_ready",  64'(a_if.in_ready), 64'd1);

        // Clear together with a cout=1 push: set wins for cout, ovf clears.
        ent = {32'hFFFF_FFF7, 5'd2, 4'b1000};
        q.push_back(ent);
        drive_a(1'b1, ent);
        a_clr = 1'b1;
        @(negedge clk);
        check("stk_set_wins", 64'({a_sovf, a_scout}), STICKY ? 64'd1 : 64'd0);
        // Clear with a non-setting push.
        ent = {32'h0000_0010, 5'd3, 4'b0000};
        q.push_back(ent);
        drive_a(1'b1, ent);
        @(negedge clk);
        a_clr = 1'b0;
        check("stk_cleared",  64'({a_sovf, a_scout}), 64'd0);
        check("cc_count0",    64'(a_count), 64'd2);

        // Concurrent push & pop for 10 cycles at count=2; pointers wrap.
        a_if.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ent = {32'h100 + 32'(k), 5'(k), 4'(k)};
            drive_a(1'b1, ent);
            check($sformatf("cc_head_%0d", k), 64'(a_head()), 64'(q[0]));
            check($sformatf("cc_cnt_%0d", k),  64'(a_count), 64'd2);
            @(negedge clk);
            void'(q.pop_front());
            q.push_back(ent);
        end
        drive_a(1'b0, ent);
        check("cc_tail0",     64'(a_head()), 64'(q[0]));
        @(negedge clk);
        check("cc_tail1",     64'(a_head()), 64'(q[1]));
        @(negedge clk);
        a_if.out_ready = 1'b0;
        check("cc_empty",     64'(a_if.out_valid), 64'd0);

        // Queue two entries, then assert reset between clock edges.
        drive_a(1'b1, fill_vec[1]);
        @(negedge clk);
        drive_a(1'b1, fill_vec[2]);
        @(negedge clk);
        drive_a(1'b0, fill_vec[2]);
        check("pre_rst_count", 64'(a_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",   64'(a_if.out_valid), 64'd0);
        check("arst_count",   64'(a_count), 64'd0);
        check("arst_ready",   64'(a_if.in_ready), 64'd1);
        check("arst_stall",   64'(a_stall), 64'd0);
        check("arst_b_stall", 64'(b_stall), 64'd0);
        check("arst_sticky",  64'({a_sovf, a_scout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(a_if.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
